// File: rtl/note_sequencer_if.sv
// Key/pitch/command bundle between the debounced front panel and the note
// sequencer. The master side drives live keys and commands; the slave side is the sequencer.
interface note_sequencer_if #(
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  key_in;
  logic [1:0]  pitch_in;
  logic        rec_btn;
  logic        play_btn;
  logic        clr_btn;
  logic [7:0]  key_out;
  logic [1:0]  pitch_out;
  logic [1:0]  state_out;
  logic [AW:0] note_count;
  logic        full;
  logic [AW-1:0] play_idx;

  modport master (
    output key_in, pitch_in, rec_btn, play_btn, clr_btn,
    input  key_out, pitch_out, state_out, note_count, full, play_idx
  );

  modport slave (
    input  key_in, pitch_in, rec_btn, play_btn, clr_btn,
    output key_out, pitch_out, state_out, note_count, full, play_idx
  );
endinterface

// File: rtl/note_sequencer.sv
// Record/playback controller in front of the key tone generator: live pass-through,
// run-length melody capture and playback. Define NOTE_SEQ_LOOP_EN for endless looped playback.
module note_sequencer #(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned DUR_W    = 8
) (
  input logic             clk,
  input logic             rst,
  note_sequencer_if.slave bus
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(TICK_DIV);
  localparam int unsigned CODE_W = 6;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
  localparam logic [AW:0]      NC_ONE   = (AW+1)'(1);
  localparam logic [AW:0]      NC_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    IDX_ONE  = AW'(1);

`ifdef NOTE_SEQ_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REC  = 2'b01,
    S_PLAY = 2'b10,
    S_GAP  = 2'b11
  } state_t;

  state_t                    state;
  logic [7:0]                key_q;
  logic [1:0]                pitch_q;
  logic [AW:0]               count_q;
  logic                      full_q;
  logic [AW-1:0]             idx_q;
  logic [CNT_W-1:0]          tick_cnt;
  logic [CODE_W-1:0]         run_code;
  logic [DUR_W-1:0]          run_dur;
  logic                      run_open;
  logic [DUR_W-1:0]          play_ticks;
  logic [CODE_W+DUR_W-1:0]   mem [DEPTH];

  logic                      tick;
  logic [2:0]                low_idx;
  logic [3:0]                n_low;
  logic [CODE_W-1:0]         cur_code;
  logic                      commit_req;
  logic                      full_now;
  logic                      mem_we;
  logic [CODE_W-1:0]         rd_code;
  logic [DUR_W-1:0]          rd_dur;
  logic [7:0]                rd_key;
  logic                      last_note;
  logic                      preempt;

  assign tick = (tick_cnt == CNT_LAST);

  // Exactly one low key is a note; anything else is a rest.
  always_comb begin
    low_idx = '0;
    n_low   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!bus.key_in[i]) begin
        low_idx = 3'(i);
        n_low   = n_low + 4'd1;
      end
    end
    cur_code = (n_low == 4'd1) ? {1'b0, low_idx, bus.pitch_in}
                               : {1'b1, 3'b000, bus.pitch_in};
  end

  // An open run closes on a different code or saturation; on stop only if not a rest.
  always_comb begin
    commit_req = 1'b0;
    if (state == S_REC && run_open) begin
      if (bus.rec_btn)
        commit_req = !run_code[CODE_W-1];
      else if (tick)
        commit_req = !(cur_code == run_code && run_dur != DUR_MAX);
    end
    full_now = (count_q == NC_FULL);
    mem_we   = commit_req && !full_now;
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[count_q[AW-1:0]] <= {run_code, run_dur};
  end

  assign rd_code   = mem[idx_q][DUR_W +: CODE_W];
  assign rd_dur    = mem[idx_q][DUR_W-1:0];
  assign rd_key    = rd_code[CODE_W-1] ? 8'hFF : ~(8'd1 << rd_code[4:2]);
  assign last_note = ({1'b0, idx_q} == count_q - NC_ONE);
  assign preempt   = (bus.key_in != 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      key_q      <= 8'hFF;
      pitch_q    <= 2'b01;
      count_q    <= '0;
      full_q     <= 1'b0;
      idx_q      <= '0;
      tick_cnt   <= '0;
      run_code   <= '0;
      run_dur    <= '0;
      run_open   <= 1'b0;
      play_ticks <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CNT_ONE;
      case (state)
        S_IDLE: begin
          key_q   <= bus.key_in;
          pitch_q <= bus.pitch_in;
          if (bus.clr_btn) begin
            count_q <= '0;
            full_q  <= 1'b0;
          end else if (bus.rec_btn) begin
            count_q  <= '0;
            full_q   <= 1'b0;
            run_open <= 1'b0;
            tick_cnt <= '0;
            state    <= S_REC;
          end else if (bus.play_btn && count_q != '0) begin
            idx_q      <= '0;
            play_ticks <= '0;
            tick_cnt   <= '0;
            state      <= S_PLAY;
          end
        end

        S_REC: begin
          key_q   <= bus.key_in;
          pitch_q <= bus.pitch_in;
          if (bus.rec_btn) begin
            run_open <= 1'b0;
            state    <= S_IDLE;
            if (commit_req) begin
              if (full_now) full_q  <= 1'b1;
              else          count_q <= count_q + NC_ONE;
            end
          end else if (tick) begin
            if (commit_req) begin
              if (full_now) begin
                full_q   <= 1'b1;
                run_open <= 1'b0;
                state    <= S_IDLE;
              end else begin
                count_q  <= count_q + NC_ONE;
                run_code <= cur_code;
                run_dur  <= DUR_ONE;
              end
            end else if (run_open) begin
              run_dur <= run_dur + DUR_ONE;
            end else if (!cur_code[CODE_W-1]) begin
              run_open <= 1'b1;
              run_code <= cur_code;
              run_dur  <= DUR_ONE;
            end
          end
        end

        S_PLAY: begin
          key_q   <= rd_key;
          pitch_q <= rd_code[1:0];
          if (bus.play_btn || preempt) begin
            key_q <= 8'hFF;
            state <= S_IDLE;
          end else if (tick) begin
            if (play_ticks == rd_dur - DUR_ONE) begin
              play_ticks <= '0;
              state      <= (!last_note || LOOP_EN) ? S_GAP : S_IDLE;
            end else begin
              play_ticks <= play_ticks + DUR_ONE;
            end
          end
        end

        S_GAP: begin
          key_q <= 8'hFF;
          if (bus.play_btn || preempt) begin
            state <= S_IDLE;
          end else if (tick) begin
            idx_q <= last_note ? '0 : idx_q + IDX_ONE;
            state <= S_PLAY;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.key_out    = key_q;
  assign bus.pitch_out  = pitch_q;
  assign bus.state_out  = state;
  assign bus.note_count = count_q;
  assign bus.full       = full_q;
  assign bus.play_idx   = idx_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: pass-through vectors plus record, playback,
// saturation, overflow, pre-emption and reset sequences at TICK_DIV=4.
module tb_note_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_sequencer_if #(.DEPTH(4)) bus ();

  note_sequencer #(.TICK_DIV(4), .DEPTH(4), .DUR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef NOTE_SEQ_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    logic [7:0] key;
    logic [1:0] pitch;
    logic [7:0] exp_key;
    logic [1:0] exp_pitch;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Plays two stored notes (3 ticks then 2 ticks) and checks every cycle.
  task automatic check_play(input logic [7:0] k0, input logic [7:0] k1);
    logic [7:0] ek;
    logic [1:0] es;
    logic [1:0] ei;
    bus.key_in   = 8'hFF;
    bus.pitch_in = 2'b01;
    bus.play_btn = 1'b1;
    cyc(1);
    bus.play_btn = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      es = (k <= 12) ? 2'b10 : (k <= 16) ? 2'b11 : (k <= 24) ? 2'b10 : (LOOP ? 2'b11 : 2'b00);
      ek = (k == 1) ? 8'hFF : (k <= 13) ? k0 : (k <= 17) ? 8'hFF : k1;
      ei = (k <= 16) ? 2'd0 : 2'd1;
      check("play_key", bus.key_out, ek);
      check("play_state", {6'd0, bus.state_out}, {6'd0, es});
      check("play_idx", {6'd0, bus.play_idx}, {6'd0, ei});
      if ((k >= 2 && k <= 13) || (k >= 18))
        check("play_pitch", {6'd0, bus.pitch_out}, 8'h02);
      cyc(1);
    end
`ifdef NOTE_SEQ_LOOP_EN
    check("loop_gap_key", bus.key_out, 8'hFF);
    check("loop_gap_state", {6'd0, bus.state_out}, 8'h03);
    cyc(3);
    check("loop_state", {6'd0, bus.state_out}, 8'h02);
    check("loop_idx", {6'd0, bus.play_idx}, 8'h00);
    cyc(1);
    check("loop_key", bus.key_out, k0);
    bus.play_btn = 1'b1;
    cyc(1);
    bus.play_btn = 1'b0;
    check("loop_stop", {6'd0, bus.state_out}, 8'h00);
    cyc(1);
`else
    check("end_key", bus.key_out, 8'hFF);
    check("end_state", {6'd0, bus.state_out}, 8'h00);
    check("end_pitch", {6'd0, bus.pitch_out}, 8'h01);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hFE, 2'b00, 8'hFE, 2'b00};
    vecs[1] = '{8'h7F, 2'b11, 8'h7F, 2'b11};
    vecs[2] = '{8'h00, 2'b10, 8'h00, 2'b10};
    vecs[3] = '{8'hAA, 2'b01, 8'hAA, 2'b01};
    vecs[4] = '{8'hFF, 2'b00, 8'hFF, 2'b00};

    rst          = 1'b1;
    bus.key_in   = 8'hFF;
    bus.pitch_in = 2'b00;
    bus.rec_btn  = 1'b0;
    bus.play_btn = 1'b0;
    bus.clr_btn  = 1'b0;
    cyc(2);
    check("rst_key", bus.key_out, 8'hFF);
    check("rst_pitch", {6'd0, bus.pitch_out}, 8'h01);
    check("rst_state", {6'd0, bus.state_out}, 8'h00);
    check("rst_count", {5'd0, bus.note_count}, 8'h00);
    check("rst_full", {7'd0, bus.full}, 8'h00);
    check("rst_idx", {6'd0, bus.play_idx}, 8'h00);
    rst = 1'b0;
    cyc(1);

    for (int i = 0; i < 5; i++) begin
      bus.key_in   = vecs[i].key;
      bus.pitch_in = vecs[i].pitch;
      cyc(1);
      check("pass_key", bus.key_out, vecs[i].exp_key);
      check("pass_pitch", {6'd0, bus.pitch_out}, {6'd0, vecs[i].exp_pitch});
    end

    // Record FE x3 ticks, FD x2, trailing rest x2.
    bus.pitch_in = 2'b10;
    bus.key_in   = 8'hFE;
    bus.rec_btn  = 1'b1;
    cyc(1);
    bus.rec_btn = 1'b0;
    check("rec_state", {6'd0, bus.state_out}, 8'h01);
    cyc(12);
    bus.key_in = 8'hFD;
    cyc(4);
    check("rec_mid_count", {5'd0, bus.note_count}, 8'h01);
    cyc(4);
    bus.key_in = 8'hFF;
    cyc(8);
    bus.rec_btn = 1'b1;
    cyc(1);
    bus.rec_btn = 1'b0;
    check("rec_done_state", {6'd0, bus.state_out}, 8'h00);
    check("rec_count", {5'd0, bus.note_count}, 8'h02);
    check("rec_full", {7'd0, bus.full}, 8'h00);
    check_play(8'hFE, 8'hFD);
    cyc(2);

    // Live key pre-empts playback.
    bus.play_btn = 1'b1;
    cyc(1);
    bus.play_btn = 1'b0;
    cyc(4);
    bus.key_in = 8'hF7;
    cyc(1);
    check("preempt_state", {6'd0, bus.state_out}, 8'h00);
    cyc(1);
    check("preempt_key", bus.key_out, 8'hF7);
    bus.key_in = 8'hFF;
    cyc(2);

    // Leading rest discarded; FE held 5 ticks saturates DUR_W=2 into 3 + 2.
    bus.pitch_in = 2'b10;
    bus.rec_btn  = 1'b1;
    cyc(1);
    bus.rec_btn = 1'b0;
    cyc(4);
    bus.key_in = 8'hFE;
    cyc(20);
    bus.key_in  = 8'hFF;
    bus.rec_btn = 1'b1;
    cyc(1);
    bus.rec_btn = 1'b0;
    check("sat_count", {5'd0, bus.note_count}, 8'h02);
    check_play(8'hFE, 8'hFE);
    cyc(2);

    // Asynchronous reset in the middle of the second note.
    bus.play_btn = 1'b1;
    cyc(1);
    bus.play_btn = 1'b0;
    cyc(19);
    check("pre_rst_idx", {6'd0, bus.play_idx}, 8'h01);
    rst = 1'b1;
    #1;
    check("mid_rst_key", bus.key_out, 8'hFF);
    check("mid_rst_pitch", {6'd0, bus.pitch_out}, 8'h01);
    check("mid_rst_state", {6'd0, bus.state_out}, 8'h00);
    check("mid_rst_count", {5'd0, bus.note_count}, 8'h00);
    check("mid_rst_idx", {6'd0, bus.play_idx}, 8'h00);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Five distinct keys into a 4-deep memory.
    bus.key_in  = 8'hFE;
    bus.rec_btn = 1'b1;
    cyc(1);
    bus.rec_btn = 1'b0;
    cyc(4);
    bus.key_in = 8'hFD;
    cyc(4);
    bus.key_in = 8'hFB;
    cyc(4);
    bus.key_in = 8'hF7;
    cyc(4);
    check("ovf_mid_count", {5'd0, bus.note_count}, 8'h03);
    bus.key_in = 8'hEF;
    cyc(4);
    bus.rec_btn = 1'b1;
    cyc(1);
    bus.rec_btn = 1'b0;
    bus.key_in  = 8'hFF;
    check("ovf_full", {7'd0, bus.full}, 8'h01);
    check("ovf_count", {5'd0, bus.note_count}, 8'h04);
    check("ovf_state", {6'd0, bus.state_out}, 8'h00);

    bus.clr_btn = 1'b1;
    cyc(1);
    bus.clr_btn = 1'b0;
    check("clr_count", {5'd0, bus.note_count}, 8'h00);
    check("clr_full", {7'd0, bus.full}, 8'h00);

    bus.play_btn = 1'b1;
    cyc(1);
    bus.play_btn = 1'b0;
    cyc(1);
    check("empty_play_state", {6'd0, bus.state_out}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Record/playback controller for the key tone generator. Sits between the debounced key/pitch inputs and the tone generator's key/pitch ports. In live mode it passes keys through. In record mode it captures the played melody as run-length notes. In playback mode it drives the stored melody into the tone generator. A live key press pre-empts playback.

## Interface
- `TICK_DIV`, 500000 — clk cycles per time tick (10 ms at 50 MHz); range 2 to 2^20.
- `DEPTH`, 32 — note memory entries; must be a power of two, at most 64.
- `DUR_W`, 8 — duration field width; the maximum note length is 2^DUR_W−1 ticks.
- `clk`  in  1  — system clock; everything is synchronous to its rising edge.
- `rst`  in  1  — asynchronous reset, active-high.
- `key_in`  in  8  — live keys, active-low, already debounced; bit i corresponds to note index i.
- `pitch_in`  in  2  — live octave select, same coding as the tone generator.
- `rec_btn`, `play_btn`, `clr_btn`  in  1 each  — single-cycle command pulses.
- `key_out`  out  8  — key code to the tone generator; 8'hFF is silence.
- `pitch_out`  out  2  — octave to the tone generator.
- `state_out`  out  2  — state code: IDLE=00, REC=01, PLAY=10, GAP=11.
- `note_count`  out  log2(DEPTH)+1  — number of stored notes.
- `full`  out  1  — the memory filled during the last recording.
- `play_idx`  out  log2(DEPTH)  — index of the note currently playing.

## Operation
**Code classification**
- A *code* is {rest, idx[2:0], pitch[1:0]}.
- key_in with exactly one low bit is a valid key: rest=0, idx = position of the low bit.
- All other patterns (none low, or more than one low) count as a rest.

**Tick prescaler**
- Counts 0..TICK_DIV−1.
- `tick` is asserted for one cycle at count TICK_DIV−1.
- The prescaler is cleared on entry to REC and on entry to PLAY.

**IDLE**
- key_out follows key_in; pitch_out follows pitch_in.
- Command priority: clr > rec > play.
- clr_btn: note_count←0, full←0.
- rec_btn: note_count←0, full←0, go to REC.
- play_btn with note_count>0: play_idx←0, go to PLAY. play_btn with note_count=0 is ignored.

**REC**
- Pass-through continues as in IDLE. The code is sampled on every tick.
- Leading rests before the first valid key are discarded.
- If the sampled code equals the open run's code and dur < max, the run's dur is incremented.
- Otherwise the open run is committed to mem[note_count], note_count is incremented, and a new run opens with dur=1.
- A run that saturates at max dur is committed, and the same code reopens as a new run.
- rec_btn: the open run is committed only if it is not a rest (trailing rest is dropped). Then go to IDLE.
- If a commit is needed while note_count = DEPTH: full←1, the run is dropped, go to IDLE.
- play_btn and clr_btn are ignored in REC.

**PLAY**
- key_out = one-hot-low of idx, or 8'hFF for a rest note; pitch_out = the stored pitch.
- The note is held for dur ticks.
- Then: if play_idx < note_count−1, go to GAP. Otherwise go to IDLE (see Configuration).

**GAP**
- key_out=8'hFF for one tick, then play_idx+1 and go to PLAY.

**Exits from PLAY or GAP**
- play_btn stops playback: go to IDLE.
- Any low bit on key_in (live pre-emption) also goes to IDLE, with pass-through from the next cycle.
- rec_btn and clr_btn are ignored in PLAY and GAP.

## Timing
- key_out, pitch_out and state_out are registered: 1 cycle of latency from inputs, commands and state changes.
- Reset values: key_out=8'hFF, pitch_out=2'b01, state_out=00, note_count=0, full=0, play_idx=0.
- Memory contents are not reset.
- The first REC sample occurs TICK_DIV cycles after the rec_btn cycle.
- The first PLAY note appears on key_out 2 cycles after play_btn.
- A note of dur d occupies d×TICK_DIV cycles; each gap occupies TICK_DIV cycles.
- Reset mid-record or mid-play aborts immediately: outputs take reset values and stored notes are lost (count=0).
- A command pulse on the same cycle as a tick is processed first; the tick is then consumed by the new state.

## Configuration
- `NOTE_SEQ_LOOP_EN` defined: after the last note, insert a GAP, set play_idx←0, and continue in PLAY indefinitely until play_btn or a live key.
- Undefined: after the last note, go to IDLE (single pass).

## Test plan
- Reset with TICK_DIV=4 → key_out=FF, pitch_out=01, state_out=00, note_count=0.
- Record: key_in=FE for 3 ticks, FD for 2 ticks, FF for 2 ticks, then rec_btn → note_count=2; mem0={0,0,pitch,3}, mem1={0,1,pitch,2}; trailing rest dropped.
- Play the above → key_out=FE for 12 cycles, FF for 4, FD for 8, then IDLE; play_idx steps 0→1.
- DUR_W=2, FE held for 5 ticks → notes of dur 3 and dur 2 stored. DEPTH=4 with 5 distinct keys → full=1, note_count=4, state returns to IDLE.
- During playback drive key_in=F7 → state_out=00 next cycle, key_out=F7 the following cycle.
- With NOTE_SEQ_LOOP_EN: after the last note, a GAP follows, then play_idx=0 and note 0 replays; play_btn stops playback. Without the macro: IDLE after the last note.
